gor_acc: RTL and testbench
==========================

GOR_ACC -- requirements
Module: gor_acc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (WIDTH >= 1).
REQ-002 The module SHALL have parameter COUNT, default 4, giving the number of operands per accumulation (COUNT >= 2).
REQ-003 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk SHALL be an input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_valid SHALL be an input, 1 bit: operand(s) present this cycle.
REQ-007 Port clr SHALL be an input, 1 bit: synchronous abort of an accumulation in progress.
REQ-008 Port mode SHALL be an input, 1 bit: 0 = pairwise, 1 = accumulate.
REQ-009 Port op SHALL be an input, 2 bits: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-010 Port a SHALL be an input, WIDTH bits: first operand (the only operand used during accumulation).
REQ-011 Port b SHALL be an input, WIDTH bits: second operand, used in pairwise mode only.
REQ-012 Port y SHALL be an output, WIDTH bits: registered result.
REQ-013 Port out_valid SHALL be an output, 1 bit: one-cycle pulse when y updates.
REQ-014 Port busy SHALL be an output, 1 bit: high while an accumulation is in progress.
REQ-015 Port cnt SHALL be an output, $clog2(COUNT)+1 bits: number of operands absorbed in the current accumulation.

Function
REQ-016 The FSM SHALL have two states: IDLE and ACC; busy SHALL be 1 exactly when the state is ACC.
REQ-017 IDLE, in_valid=1, mode=0: y <= a op b and out_valid=1 on the following cycle (latency 1); state stays IDLE.
REQ-018 IDLE, in_valid=1, mode=1: acc <= a, cnt <= 1, op is latched, state -> ACC; no out_valid pulse.
REQ-019 ACC, in_valid=1: acc <= acc op_latched a; cnt increments; b, mode and the live op input are ignored.
REQ-020 NOR in accumulation SHALL be computed as acc <= ~(acc | a) at each step.
REQ-021 When the absorbed operand makes cnt reach COUNT: y <= new acc, out_valid pulses for 1 cycle, cnt <= 0, state -> IDLE.
REQ-022 ACC, in_valid=0: acc, cnt and state SHALL hold; no timeout applies.
REQ-023 clr=1 SHALL force state IDLE and cnt 0, with y unchanged and no out_valid; clr wins over a simultaneous in_valid.
REQ-024 y SHALL hold its last result until the next result is produced; out_valid SHALL never stay high for 2 consecutive cycles unless in_valid produces back-to-back pairwise results.
REQ-025 All operations SHALL be bitwise on WIDTH bits, with no carries and no width extension.

Reset
REQ-026 While rst=1, asynchronously: state IDLE, y=0, acc=0, cnt=0, out_valid=0, busy=0.
REQ-027 Reset asserted mid-accumulation SHALL discard partial results; after release, the first in_valid starts fresh.

Verification (WIDTH=16, COUNT=4)
REQ-028 Pairwise OR, a=0x00F0, b=0x0F0F -> next cycle y=0x0FFF, out_valid=1 for 1 cycle, busy=0.
REQ-029 Pairwise NOR, a=0x0000, b=0x0000 -> y=0xFFFF; then pairwise AND with a=0xF0F0, b=0xFF00 on the next cycle -> y=0xF000, out_valid high 2 cycles.
REQ-030 Accumulate OR with 0x0001, 0x0002, 0x0004, 0x0008 on consecutive cycles -> cnt 1,2,3; busy high; then y=0x000F, out_valid single pulse, cnt=0.
REQ-031 Accumulate XOR with 0xFFFF, 0x00FF, 0x0F0F, 0x3333, idle gaps between them, op changed to AND mid-run -> y=0xC33C.
REQ-032 Accumulate, 2 operands, then clr together with in_valid -> no out_valid, cnt=0, busy=0, y unchanged.
REQ-033 rst pulsed mid-accumulation (cnt=3) -> y=0, cnt=0, busy=0 immediately, without waiting for a clock edge; the next 4-operand run gives the correct result.

Source files
------------

// File: rtl/gor_acc_if.sv
// gor_acc_if -- operand/result bundle for the gor_acc bitwise logic unit.
//   master : drives in_valid, clr, mode, op, a, b; observes y, out_valid, busy, cnt
//   slave  : the gor_acc core (inverse directions)
//   WIDTH  : operand/result width in bits
//   COUNT  : operands per accumulation; cnt is $clog2(COUNT)+1 bits wide
interface gor_acc_if #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4
);
  logic                     in_valid;
  logic                     clr;
  logic                     mode;
  logic [1:0]               op;
  logic [WIDTH-1:0]         a;
  logic [WIDTH-1:0]         b;
  logic [WIDTH-1:0]         y;
  logic                     out_valid;
  logic                     busy;
  logic [$clog2(COUNT):0]   cnt;

  modport master (
    output in_valid, clr, mode, op, a, b,
    input  y, out_valid, busy, cnt
  );

  modport slave (
    input  in_valid, clr, mode, op, a, b,
    output y, out_valid, busy, cnt
  );
endinterface

// File: rtl/gor_acc.sv
// gor_acc -- bitwise OR/AND/XOR/NOR unit with pairwise and accumulate modes.
//   clk  : single clock, rising-edge state updates
//   rst  : asynchronous active-high reset
//   bus  : gor_acc_if.slave
//          in_valid/clr/mode/op/a/b in; y (registered result), out_valid
//          (one-cycle result pulse), busy (accumulating), cnt (operands absorbed) out
// Pairwise mode produces a op b one cycle after in_valid. Accumulate mode folds
// COUNT consecutive valid 'a' operands with the op captured on the first one.
module gor_acc #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4
) (
  input  logic    clk,
  input  logic    rst,
  gor_acc_if.slave bus
);

  localparam int CW = $clog2(COUNT) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] acc_next_s;
  logic [CW-1:0]    cnt_inc_s;

  // Bitwise combine; NOR is the inverted OR of the two operands.
  function automatic logic [WIDTH-1:0] logic_op(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z,
    input logic [1:0]       sel
  );
    logic [WIDTH-1:0] r;
    case (sel)
      OP_OR:   r = x | z;
      OP_AND:  r = x & z;
      OP_XOR:  r = x ^ z;
      OP_NOR:  r = ~(x | z);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  assign acc_next_s = logic_op(acc_q, bus.a, op_q);
  assign cnt_inc_s  = cnt_q + CNT_ONE;

  // Next-state and datapath update; clr overrides any in_valid activity.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.mode == 1'b0) begin
              y_d         = logic_op(bus.a, bus.b, bus.op);
              out_valid_d = 1'b1;
            end else begin
              acc_d   = bus.a;
              cnt_d   = CNT_ONE;
              op_d    = bus.op;
              state_d = ACC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc_d = acc_next_s;
            // The operand that fills the run publishes the result.
            if (cnt_inc_s == CNT_LAST) begin
              y_d         = acc_next_s;
              out_valid_d = 1'b1;
              cnt_d       = CNT_ZERO;
              state_d     = IDLE;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            state_d = ACC;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= CNT_ZERO;
      op_q        <= 2'b00;
      y_q         <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ACC);
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_gor_acc.sv
module tb_gor_acc;

  localparam int W = 16;
  localparam int N = 4;

  logic clk;
  logic rst;

  gor_acc_if #(.WIDTH(W), .COUNT(N)) bus ();

  gor_acc #(.WIDTH(W), .COUNT(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        iv;
    logic        clr;
    logic        mode;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ey;
    logic        eov;
    logic        ebusy;
    logic [2:0]  ecnt;
  } vec_t;

  vec_t vecs [25];

  // reference model state: list of absorbed operands + latched op
  logic [15:0] m_list[$];
  logic        m_busy;
  logic [1:0]  m_op;
  logic [15:0] m_y;
  logic        m_ov;

  function automatic logic [15:0] ref_op(input logic [15:0] x, input logic [15:0] z, input logic [1:0] o);
    case (o)
      2'b00:   return x | z;
      2'b01:   return x & z;
      2'b10:   return x ^ z;
      default: return ~(x | z);
    endcase
  endfunction

  task automatic model_reset();
    m_list.delete();
    m_busy = 1'b0;
    m_op   = 2'b00;
    m_y    = 16'h0000;
    m_ov   = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic c, input logic md,
                            input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    m_ov = 1'b0;
    if (c) begin
      m_list.delete();
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (iv && !md) begin
        m_y  = ref_op(a, b, o);
        m_ov = 1'b1;
      end else if (iv) begin
        m_list.push_back(a);
        m_op   = o;
        m_busy = 1'b1;
      end
    end else if (iv) begin
      m_list.push_back(a);
      if (m_list.size() == N) begin
        r = m_list[0];
        for (int k = 1; k < N; k++) r = ref_op(r, m_list[k], m_op);
        m_y  = r;
        m_ov = 1'b1;
        m_list.delete();
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] ey, input logic eov,
                           input logic ebusy, input logic [2:0] ecnt);
    check({tag, ".y"},         32'(bus.y),         32'(ey));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(eov));
    check({tag, ".busy"},      32'(bus.busy),      32'(ebusy));
    check({tag, ".cnt"},       32'(bus.cnt),       32'(ecnt));
  endtask

  task automatic drive(input logic iv, input logic c, input logic md,
                       input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = iv;
    bus.clr      = c;
    bus.mode     = md;
    bus.op       = o;
    bus.a        = a;
    bus.b        = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // iv clr mode op a b | y ov busy cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,2'b00,16'h00F0,16'h0F0F, 16'h0FFF,1'b1,1'b0,3'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000, 16'h0FFF,1'b0,1'b0,3'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,2'b11,16'h0000,16'h0000, 16'hFFFF,1'b1,1'b0,3'd0};
    vecs[3]  = '{1'b1,1'b0,1'b0,2'b01,16'hF0F0,16'hFF00, 16'hF000,1'b1,1'b0,3'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000, 16'hF000,1'b0,1'b0,3'd0};
    vecs[5]  = '{1'b1,1'b0,1'b1,2'b00,16'h0001,16'hAAAA, 16'hF000,1'b0,1'b1,3'd1};
    vecs[6]  = '{1'b1,1'b0,1'b1,2'b00,16'h0002,16'h5555, 16'hF000,1'b0,1'b1,3'd2};
    vecs[7]  = '{1'b1,1'b0,1'b1,2'b00,16'h0004,16'h0000, 16'hF000,1'b0,1'b1,3'd3};
    vecs[8]  = '{1'b1,1'b0,1'b1,2'b00,16'h0008,16'h0000, 16'h000F,1'b1,1'b0,3'd0};
    vecs[9]  = '{1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000, 16'h000F,1'b0,1'b0,3'd0};
    vecs[10] = '{1'b1,1'b0,1'b1,2'b10,16'hFFFF,16'h0000, 16'h000F,1'b0,1'b1,3'd1};
    vecs[11] = '{1'b0,1'b0,1'b0,2'b01,16'h1234,16'h0000, 16'h000F,1'b0,1'b1,3'd1};
    vecs[12] = '{1'b1,1'b0,1'b0,2'b01,16'h00FF,16'h1234, 16'h000F,1'b0,1'b1,3'd2};
    vecs[13] = '{1'b0,1'b0,1'b1,2'b01,16'h0000,16'h0000, 16'h000F,1'b0,1'b1,3'd2};
    vecs[14] = '{1'b1,1'b0,1'b1,2'b01,16'h0F0F,16'h0000, 16'h000F,1'b0,1'b1,3'd3};
    vecs[15] = '{1'b0,1'b0,1'b0,2'b01,16'h0000,16'h0000, 16'h000F,1'b0,1'b1,3'd3};
    vecs[16] = '{1'b1,1'b0,1'b0,2'b01,16'h3333,16'h0000, 16'hC33C,1'b1,1'b0,3'd0};
    vecs[17] = '{1'b1,1'b0,1'b1,2'b00,16'h1111,16'h0000, 16'hC33C,1'b0,1'b1,3'd1};
    vecs[18] = '{1'b1,1'b0,1'b1,2'b00,16'h2222,16'h0000, 16'hC33C,1'b0,1'b1,3'd2};
    vecs[19] = '{1'b1,1'b1,1'b1,2'b00,16'h4444,16'h0000, 16'hC33C,1'b0,1'b0,3'd0};
    vecs[20] = '{1'b0,1'b0,1'b0,2'b00,16'h0000,16'h0000, 16'hC33C,1'b0,1'b0,3'd0};
    vecs[21] = '{1'b1,1'b0,1'b1,2'b11,16'h00FF,16'h0000, 16'hC33C,1'b0,1'b1,3'd1};
    vecs[22] = '{1'b1,1'b0,1'b1,2'b00,16'h0F00,16'h0000, 16'hC33C,1'b0,1'b1,3'd2};
    vecs[23] = '{1'b1,1'b0,1'b1,2'b00,16'h0001,16'h0000, 16'hC33C,1'b0,1'b1,3'd3};
    vecs[24] = '{1'b1,1'b0,1'b1,2'b00,16'h1000,16'h0000, 16'hE001,1'b1,1'b0,3'd0};

    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    rst = 1'b1;
    #2;
    check_all("reset", 16'h0000, 1'b0, 1'b0, 3'd0);
    step();
    rst = 1'b0;
    #1;

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].iv, vecs[i].clr, vecs[i].mode, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].ey, vecs[i].eov, vecs[i].ebusy, vecs[i].ecnt);
    end

    // reset mid-accumulation at cnt=3, asserted away from a clock edge
    drive(1'b1, 1'b0, 1'b1, 2'b01, 16'hFFFF, 16'h0000); step();
    drive(1'b1, 1'b0, 1'b1, 2'b01, 16'hFF0F, 16'h0000); step();
    drive(1'b1, 1'b0, 1'b1, 2'b01, 16'hF0FF, 16'h0000); step();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    check_all("pre_rst", 16'hE001, 1'b0, 1'b1, 3'd3);
    #1;
    rst = 1'b1;
    #1;
    check_all("async_rst", 16'h0000, 1'b0, 1'b0, 3'd0);
    #3;
    rst = 1'b0;
    step();
    drive(1'b1, 1'b0, 1'b1, 2'b10, 16'h0001, 16'h0000); step();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 16'h0002, 16'h0000); step();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 16'h0004, 16'h0000); step();
    drive(1'b1, 1'b0, 1'b1, 2'b00, 16'h0008, 16'h0000); step();
    check_all("post_rst_run", 16'h000F, 1'b1, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000); step();
    check_all("post_rst_idle", 16'h000F, 1'b0, 1'b0, 3'd0);

    // randomized run against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 600; i++) begin
      logic        r_iv, r_clr, r_md;
      logic [1:0]  r_op;
      logic [15:0] r_a, r_b;
      r_iv  = ($urandom_range(0, 9) < 7);
      r_clr = ($urandom_range(0, 19) == 0);
      r_md  = ($urandom_range(0, 3) != 0);
      r_op  = 2'($urandom_range(0, 3));
      r_a   = 16'($urandom);
      r_b   = 16'($urandom);
      drive(r_iv, r_clr, r_md, r_op, r_a, r_b);
      model_step(r_iv, r_clr, r_md, r_op, r_a, r_b);
      step();
      check_all($sformatf("rnd%0d", i), m_y, m_ov, m_busy, 3'(m_list.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
